// File: rtl/uart_pkg.sv
// Shared constants, arbiter FSM encoding and small helpers for the UART transmit path.
// The optional idle timeout (UART_TX_ARB_TIMEOUT_EN) takes its default length from here.
package uart_pkg;

   localparam int CLK_HZ          = 12_000_000;
   localparam int BAUD            = 115200;
   localparam int BIT_CYCLES      = CLK_HZ / BAUD;
   localparam int TIMEOUT_DEFAULT = 65535;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARB   = 3'd1,
      S_ISSUE = 3'd2,
      S_ARM   = 3'd3,
      S_DRAIN = 3'd4
   } arb_state_t;

   // Increment an index with wrap to zero at n.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// The slave modport is the arbiter; master is the requester/transmitter side.
interface uart_tx_arbiter_if #(
   parameter int NREQ = 3,
   parameter int IDW  = 3
) ();

   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx_busy;
   logic [NREQ-1:0]   grant;
   logic [IDW-1:0]    grant_id;

   modport master (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, tx_start, tx_data, grant, grant_id
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, tx_start, tx_data, grant, grant_id
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid bit at or after ptr, wrapping modulo NREQ.
// Returns a one-hot pick, its binary index and a found flag.
module rr_pick #(
   parameter int NREQ = 3,
   parameter int IDW  = 3
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] pick,
   output logic [IDW-1:0]  pick_id,
   output logic            found
);

   // Outer loop is the distance from ptr, so the nearest valid requester wins.
   always_comb begin
      pick    = '0;
      pick_id = '0;
      found   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && valid[i] && (i == (int'(ptr) + k) % NREQ)) begin
               found   = 1'b1;
               pick[i] = 1'b1;
               pick_id = IDW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx between NREQ requesters.
// Define UART_TX_ARB_TIMEOUT_EN to release a grant whose owner stalls mid-packet.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int IDW  = 3
) (
   input  logic clk,
   input  logic rst,
`ifdef UART_TX_ARB_TIMEOUT_EN
   output logic timeout_pulse,
`endif
   uart_tx_arbiter_if.slave bus
);

   arb_state_t      state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [IDW-1:0]  grant_id_q, grant_id_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [NREQ-1:0] req_ready_q, req_ready_d;
   logic            tx_start_q, tx_start_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            last_q, last_d;
   logic            release_now;

   logic [NREQ-1:0] pick;
   logic [IDW-1:0]  pick_id;
   logic            found;

   logic            owner_valid;
   logic            owner_last;
   logic [7:0]      owner_data;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TIMEOUT = TIMEOUT_DEFAULT;
   logic [15:0] idle_cnt_q, idle_cnt_d;
   logic        timeout_q, timeout_d;
`endif

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .valid   (bus.req_valid),
      .ptr     (rr_ptr_q),
      .pick    (pick),
      .pick_id (pick_id),
      .found   (found)
   );

   // Owner's lane is selected through the one-hot grant.
   always_comb begin
      owner_valid = 1'b0;
      owner_last  = 1'b0;
      owner_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_q[i]) begin
            owner_valid = bus.req_valid[i];
            owner_last  = bus.req_last[i];
            owner_data  = bus.req_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      grant_id_d  = grant_id_q;
      rr_ptr_d    = rr_ptr_q;
      last_d      = last_q;
      tx_start_d  = 1'b0;
      tx_data_d   = tx_data_q;
      req_ready_d = '0;
      release_now = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      idle_cnt_d  = idle_cnt_q;
      timeout_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: state_d = S_ARB;
         S_ARB: begin
            if (found) begin
               grant_d    = pick;
               grant_id_d = pick_id;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (owner_valid && !bus.tx_busy) begin
               tx_start_d  = 1'b1;
               tx_data_d   = owner_data;
               req_ready_d = grant_q;
               last_d      = owner_last;
               state_d     = S_ARM;
`ifdef UART_TX_ARB_TIMEOUT_EN
               idle_cnt_d  = '0;
`endif
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            else if (!owner_valid) begin
               if (idle_cnt_q == 16'(TIMEOUT - 1)) begin
                  release_now = 1'b1;
                  timeout_d   = 1'b1;
                  idle_cnt_d  = '0;
               end else begin
                  idle_cnt_d  = idle_cnt_q + 16'd1;
               end
            end
`endif
         end
         // tx_busy only rises the cycle after tx_start, so ARM skips that blind cycle.
         S_ARM: state_d = S_DRAIN;
         S_DRAIN: begin
            if (!bus.tx_busy) begin
               if (last_q) release_now = 1'b1;
               else        state_d     = S_ISSUE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (release_now) begin
         grant_d    = '0;
         grant_id_d = '0;
         rr_ptr_d   = IDW'(wrap_inc(int'(grant_id_q), NREQ));
         state_d    = S_ARB;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         grant_id_q  <= '0;
         rr_ptr_q    <= '0;
         last_q      <= 1'b0;
         tx_start_q  <= 1'b0;
         tx_data_q   <= '0;
         req_ready_q <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         idle_cnt_q  <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         grant_id_q  <= grant_id_d;
         rr_ptr_q    <= rr_ptr_d;
         last_q      <= last_d;
         tx_start_q  <= tx_start_d;
         tx_data_q   <= tx_data_d;
         req_ready_q <= req_ready_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
         idle_cnt_q  <= idle_cnt_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.tx_start  = tx_start_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.grant     = grant_q;
   assign bus.grant_id  = grant_id_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
   assign timeout_pulse = timeout_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table of arbitration vectors plus directed
// multi-cycle sequences; the timeout sequence runs only with UART_TX_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int NREQ        = 3;
   localparam int IDW         = 3;
   localparam int BYTE_CYCLES = 10 * BIT_CYCLES;
   localparam int QDEPTH      = 16;
   localparam int LOGDEPTH    = 128;

   typedef struct packed {
      logic [2:0] mask;
      logic [7:0] d0, d1, d2;
      logic [1:0] n;
      logic [2:0] g0, g1, g2;
      logic [7:0] e0, e1, e2;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic extBusy = 1'b0;
   int   busyCnt = 0;

   int checks = 0;
   int failures = 0;

   logic [7:0] qData [NREQ][QDEPTH];
   logic       qLast [NREQ][QDEPTH];
   int         qHead [NREQ];
   int         qTail [NREQ];

   logic [7:0] startData  [LOGDEPTH];
   logic [2:0] startGrant [LOGDEPTH];
   int         startCount = 0;
   int         readyCount [NREQ];

   uart_tx_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef UART_TX_ARB_TIMEOUT_EN
   logic timeout_pulse;
`endif

   uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk           (clk),
      .rst           (rst),
`ifdef UART_TX_ARB_TIMEOUT_EN
      .timeout_pulse (timeout_pulse),
`endif
      .bus           (bus)
   );

   initial forever #5 clk = ~clk;

   // Transmitter model: busy from the cycle after tx_start for one full 10-bit frame.
   always @(posedge clk) begin
      if (bus.tx_start) busyCnt <= BYTE_CYCLES;
      else if (busyCnt != 0) busyCnt <= busyCnt - 1;
   end
   assign bus.tx_busy = (busyCnt != 0) || extBusy;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int req, input logic [7:0] data, input logic last);
      qData[req][qTail[req] % QDEPTH] = data;
      qLast[req][qTail[req] % QDEPTH] = last;
      qTail[req]++;
   endtask

   task automatic waitStarts(input int target, input int budget, input string name);
      int n = 0;
      while (startCount < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, (startCount >= target), 1);
   endtask

   task automatic waitIdle(input string name);
      int n = 0;
      while ((bus.grant != '0 || bus.tx_busy) && n < 3 * BYTE_CYCLES) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, bus.grant, 0);
   endtask

   task automatic expStart(input int idx, input logic [7:0] data, input logic [2:0] grant, input string name);
      checkOutput({name, "_data"}, startData[idx], data);
      checkOutput({name, "_grant"}, startGrant[idx], grant);
   endtask

   // Requester models: present queue head, pop on the req_ready pulse.
   initial begin
      for (int i = 0; i < NREQ; i++) begin
         qHead[i] = 0;
         qTail[i] = 0;
      end
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_ready[i] && qHead[i] < qTail[i]) qHead[i]++;
            bus.req_valid[i]       = (qHead[i] < qTail[i]);
            bus.req_data[8*i +: 8] = qData[i][qHead[i] % QDEPTH];
            bus.req_last[i]        = qLast[i][qHead[i] % QDEPTH];
         end
      end
   end

   // Event log plus invariants that hold on every cycle.
   initial begin
      logic [7:0] prevData;
      bit         skipStable;
      prevData   = '0;
      skipStable = 1'b1;
      for (int i = 0; i < NREQ; i++) readyCount[i] = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            skipStable = 1'b1;
         end else begin
            if (bus.tx_start) begin
               if (startCount < LOGDEPTH) begin
                  startData[startCount]  = bus.tx_data;
                  startGrant[startCount] = bus.grant;
               end
               startCount++;
               checkOutput("start_while_busy", bus.tx_busy, 0);
            end else begin
               if (bus.req_ready != '0) checkOutput("ready_without_start", bus.req_ready, 0);
               if (!skipStable && bus.tx_data !== prevData) checkOutput("tx_data_stable", bus.tx_data, prevData);
            end
            for (int i = 0; i < NREQ; i++) readyCount[i] += bus.req_ready[i];
            skipStable = 1'b0;
         end
         prevData = bus.tx_data;
      end
   end

   initial begin
      vec_t       vecs [7];
      logic [7:0] din [NREQ];
      logic [7:0] ed [3];
      logic [2:0] eg [3];
      int         base;
      int         rb [NREQ];
      int         n;

      vecs[0] = '{3'b111, 8'h41, 8'h42, 8'h43, 2'd3, 3'b001, 3'b010, 3'b100, 8'h41, 8'h42, 8'h43};
      vecs[1] = '{3'b110, 8'h00, 8'h51, 8'h52, 2'd2, 3'b010, 3'b100, 3'b000, 8'h51, 8'h52, 8'h00};
      vecs[2] = '{3'b101, 8'h60, 8'h00, 8'h62, 2'd2, 3'b001, 3'b100, 3'b000, 8'h60, 8'h62, 8'h00};
      vecs[3] = '{3'b010, 8'h00, 8'h71, 8'h00, 2'd1, 3'b010, 3'b000, 3'b000, 8'h71, 8'h00, 8'h00};
      vecs[4] = '{3'b011, 8'h80, 8'h81, 8'h00, 2'd2, 3'b001, 3'b010, 3'b000, 8'h80, 8'h81, 8'h00};
      vecs[5] = '{3'b111, 8'h90, 8'h91, 8'h92, 2'd3, 3'b100, 3'b001, 3'b010, 8'h92, 8'h90, 8'h91};
      vecs[6] = '{3'b100, 8'h00, 8'h00, 8'hA2, 2'd1, 3'b100, 3'b000, 3'b000, 8'hA2, 8'h00, 8'h00};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_req_ready", bus.req_ready, 0);
      checkOutput("reset_tx_start", bus.tx_start, 0);
      checkOutput("reset_tx_data", bus.tx_data, 0);
      checkOutput("reset_grant", bus.grant, 0);
      checkOutput("reset_grant_id", bus.grant_id, 0);
`ifdef UART_TX_ARB_TIMEOUT_EN
      checkOutput("reset_timeout_pulse", timeout_pulse, 0);
`endif
      rst = 1'b0;
      repeat (3) @(posedge clk);

      // Round-robin table: single-byte packets raised together, rr_ptr carried across rows.
      for (int r = 0; r < 7; r++) begin
         din = '{vecs[r].d0, vecs[r].d1, vecs[r].d2};
         ed  = '{vecs[r].e0, vecs[r].e1, vecs[r].e2};
         eg  = '{vecs[r].g0, vecs[r].g1, vecs[r].g2};
         base = startCount;
         for (int i = 0; i < NREQ; i++) rb[i] = readyCount[i];
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++)
            if (vecs[r].mask[i]) applyStimulus(i, din[i], 1'b1);
         waitStarts(base + int'(vecs[r].n), int'(vecs[r].n) * (BYTE_CYCLES + 50) + 100,
                    $sformatf("vec%0d_starts", r));
         for (int k = 0; k < int'(vecs[r].n); k++)
            expStart(base + k, ed[k], eg[k], $sformatf("vec%0d_byte%0d", r, k));
         waitIdle($sformatf("vec%0d_idle", r));
         for (int i = 0; i < NREQ; i++)
            checkOutput($sformatf("vec%0d_ready%0d", r, i), readyCount[i] - rb[i], 32'(vecs[r].mask[i]));
      end

      // Single requester, three-byte packet; checks start latency and inter-byte gap.
      base = startCount;
      rb[0] = readyCount[0];
      @(posedge clk);
      #1;
      applyStimulus(0, 8'h33, 1'b0);
      applyStimulus(0, 8'h37, 1'b0);
      applyStimulus(0, 8'h0A, 1'b1);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.tx_start && n < 20);
      checkOutput("idle_start_latency", n, 2);
      n = 0;
      while (!bus.tx_busy && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      n = 0;
      while (bus.tx_busy && n < 2 * BYTE_CYCLES) begin
         @(posedge clk);
         #1;
         n++;
      end
      // First low-busy cycle is DRAIN, then ISSUE registers the start on the next edge.
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.tx_start && n < 20);
      checkOutput("interbyte_latency", n, 2);
      waitStarts(base + 3, 2 * (BYTE_CYCLES + 50), "single_starts");
      expStart(base + 0, 8'h33, 3'b001, "single_b0");
      expStart(base + 1, 8'h37, 3'b001, "single_b1");
      expStart(base + 2, 8'h0A, 3'b001, "single_b2");
      waitIdle("single_idle");
      checkOutput("single_ready0", readyCount[0] - rb[0], 3);

      // Requester 0 joins mid-packet and must wait for requester 1's last byte.
      base = startCount;
      @(posedge clk);
      #1;
      applyStimulus(1, 8'h10, 1'b0);
      applyStimulus(1, 8'h11, 1'b1);
      waitStarts(base + 1, BYTE_CYCLES, "nointerleave_first");
      applyStimulus(0, 8'h00, 1'b1);
      waitStarts(base + 3, 3 * (BYTE_CYCLES + 50), "nointerleave_starts");
      expStart(base + 0, 8'h10, 3'b010, "nointerleave_b0");
      expStart(base + 1, 8'h11, 3'b010, "nointerleave_b1");
      expStart(base + 2, 8'h00, 3'b001, "nointerleave_b2");
      waitIdle("nointerleave_idle");

      // External user holds the transmitter busy: no start until it lets go.
      base = startCount;
      @(posedge clk);
      #1;
      extBusy = 1'b1;
      applyStimulus(0, 8'h5A, 1'b1);
      repeat (50) @(posedge clk);
      #1;
      checkOutput("extbusy_no_start", startCount - base, 0);
      checkOutput("extbusy_grant_held", bus.grant, 3'b001);
      extBusy = 1'b0;
      waitStarts(base + 1, 20, "extbusy_start");
      repeat (10) @(negedge clk);
      checkOutput("extbusy_single_start", startCount - base, 1);
      expStart(base, 8'h5A, 3'b001, "extbusy_b0");
      waitIdle("extbusy_idle");

      // Reset in DRAIN of the second byte; the third byte must never go out.
      base = startCount;
      @(posedge clk);
      #1;
      applyStimulus(1, 8'h21, 1'b0);
      applyStimulus(1, 8'h22, 1'b0);
      applyStimulus(1, 8'h23, 1'b1);
      waitStarts(base + 2, 2 * (BYTE_CYCLES + 50), "rst_pre_starts");
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) qHead[i] = qTail[i];
      @(posedge clk);
      #1;
      checkOutput("rst_grant", bus.grant, 0);
      checkOutput("rst_grant_id", bus.grant_id, 0);
      checkOutput("rst_tx_start", bus.tx_start, 0);
      checkOutput("rst_req_ready", bus.req_ready, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(0, 8'h60, 1'b1);
      applyStimulus(1, 8'h61, 1'b1);
      waitStarts(base + 4, 3 * (BYTE_CYCLES + 50), "rst_post_starts");
      expStart(base + 2, 8'h60, 3'b001, "rst_post_b0");
      expStart(base + 3, 8'h61, 3'b010, "rst_post_b1");
      waitIdle("rst_post_idle");

`ifdef UART_TX_ARB_TIMEOUT_EN
      // Owner 2 stalls after a non-last byte; the timeout hands the line to requester 0.
      begin
         bit seen;
         base = startCount;
         @(posedge clk);
         #1;
         applyStimulus(2, 8'h77, 1'b0);
         waitStarts(base + 1, BYTE_CYCLES, "timeout_first");
         expStart(base, 8'h77, 3'b100, "timeout_b0");
         applyStimulus(0, 8'h70, 1'b1);
         seen = 1'b0;
         n = 0;
         while (!seen && n < TIMEOUT_DEFAULT + 5000) begin
            @(negedge clk);
            n++;
            if (timeout_pulse) begin
               seen = 1'b1;
               checkOutput("timeout_grant_released", bus.grant, 0);
            end
         end
         checkOutput("timeout_seen", seen, 1);
         @(negedge clk);
         checkOutput("timeout_single_pulse", timeout_pulse, 0);
         waitStarts(base + 2, BYTE_CYCLES, "timeout_next_start");
         expStart(base + 1, 8'h70, 3'b001, "timeout_b1");
         waitIdle("timeout_idle");
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART byte transmitter (uart_tx, 115200 baud at 12 MHz) between NREQ packet requesters, e.g. echo path, status reporter and debug dump.
- Round-robin arbitration at packet granularity: a grant holds until the requester's byte flagged last has been handed to the transmitter.
- Sits between the requesters and uart_tx inside uart_top. It sequences the transmitter's start/busy handshake so no byte is lost or overlapped.

Parameters:
- NREQ, 3, number of requesters (2..8).
- IDW, 3, width of the granted-index output; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  system clock, 12 MHz.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  in  NREQ  per-requester flag: the current byte ends the packet.
- req_ready  out  NREQ  one-hot, single-cycle pulse: byte accepted.
- tx_start  out  1  single-cycle pulse: the transmitter latches tx_data.
- tx_data  out  8  byte to the transmitter; registered and stable from tx_start until the next tx_start.
- tx_busy  in  1  transmitter busy; rises the cycle after tx_start and falls after the stop bit.
- grant  out  NREQ  one-hot, current packet owner; all zero when idle.
- grant_id  out  IDW  binary index of the owner; 0 when idle.

Behaviour:
- Reset values: req_ready=0, tx_start=0, tx_data=0, grant=0, grant_id=0, rr_ptr=0, state=IDLE.
- State machine: IDLE -> ARB -> ISSUE -> ARM -> DRAIN.
  - IDLE: the arbiter idles with grant=0.
  - ARB: if any req_valid is high, scan from rr_ptr upward with modulo-NREQ wrap and take the first valid requester. Register grant/grant_id, then go to ISSUE. With no req_valid, stay in ARB (ARB doubles as idle, grant=0).
  - ISSUE: while the owner's req_valid=1 and tx_busy=0, in a single cycle:
    - tx_start=1;
    - tx_data = the owner's req_data;
    - req_ready[owner]=1;
    - capture the owner's req_last into last_q;
    - go to ARM.
  - ISSUE otherwise waits.
  - ARM: wait exactly 1 cycle to cover the tx_busy rise latency, then go to DRAIN.
  - DRAIN: wait for tx_busy=0.
    - If last_q=1: rr_ptr = owner+1 (wraps to 0 at NREQ), grant cleared, go to ARB.
    - If last_q=0: go to ISSUE, keeping the grant.
- Latency:
  - Request to tx_start is 2 cycles when idle (ARB register, then ISSUE).
  - Between bytes of one packet there is 1 cycle after tx_busy falls (DRAIN→ISSUE, then start).
- Fairness: a requester that has just finished a packet has the lowest priority at the next arbitration. Non-owners' req_valid is ignored while a grant is held.
- Single-byte packet: req_last=1 on the first byte; the grant is released after that byte drains.
- Owner drops req_valid mid-packet: the grant is held indefinitely and ISSUE waits (without the optional feature).
- Simultaneous req_valid on all inputs with rr_ptr=0: grant order is 0,1,2,0,…
- tx_busy already high on entry to ISSUE (an external user of the transmitter): no start is issued until it is low.
- rst mid-packet: all state returns to reset values within the same edge and the partially sent packet is abandoned. A tx_start that was pulsing is not reissued.
- req_ready is never asserted for a non-owner. At most one tx_start per tx_busy low period.

Optional Feature:
- Macro UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - Adds localparam TIMEOUT=65535 and a 16-bit idle counter.
  - The counter is cleared on each tx_start and increments while in ISSUE with the owner's req_valid=0.
  - On reaching TIMEOUT, the grant is released as if last_q=1 (rr_ptr advances) and the arbiter returns to ARB.
  - Adds output port timeout_pulse (1 bit), a single-cycle pulse on release, 0 at reset.
- Undefined: no counter, no port; the grant is held until the last byte.

Decomposition:
- Package uart_pkg holds:
  - state encoding constants S_IDLE/S_ARB/S_ISSUE/S_ARM/S_DRAIN (3 bits);
  - CLK_HZ=12_000_000, BAUD=115200, BIT_CYCLES=104;
  - TIMEOUT default.
- One natural sub-module: rr_pick, combinational. Inputs are the valid vector and rr_ptr; outputs are a one-hot pick and its index. It is reusable for future RX-side routing.

Test Plan:
- Transmitter model: busy for 10*BIT_CYCLES=1040 cycles after each tx_start, so each byte occupies 1040+ cycles.
- Single requester 0 sends "3","7","\n" (0x33,0x37,0x0A, last on 0x0A) -> three tx_start pulses in order; grant=001 throughout, then 000; rr_ptr=1.
- Requesters 0,1,2 all valid with 1-byte packets 0x41,0x42,0x43 asserted in the same cycle -> tx_data order 0x41,0x42,0x43; grant sequence 001,010,100; each req_ready pulses exactly once.
- Requester 1 sends a 2-byte packet 0x10,0x11 while requester 0 raises valid after the first byte -> 0x10,0x11 complete before 0x00 data from requester 0 (no interleave).
- Model holds tx_busy=1 for 50 cycles before the first request -> tx_start is delayed until busy is low, with no double start.
- rst pulsed in DRAIN of the second byte of a 3-byte packet -> next cycle grant=0, tx_start=0, rr_ptr=0; a fresh request is serviced normally.
- With UART_TX_ARB_TIMEOUT_EN, requester 2 sends one non-last byte then drops valid -> timeout_pulse after 65535 idle cycles, grant released, and a waiting requester 0 is granted next.
